matrix_step_scheduler: RTL
==========================

MATRIX_STEP_SCHEDULER -- requirements
Module: matrix_step_scheduler

Interface
REQ-001 Parameter STEP_PERIOD, default 25000000, clock cycles between consecutive desce_jogada pulses (minimum 4).
REQ-002 Parameter MAX_BLOQ, default 7, number of blocked lines at which the game ends (range 1..7).
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 iniciar  in  1  start/restart request, level sampled each cycle.
REQ-006 botoes  in  4  player lane buttons, active-high, synchronous to clock.
REQ-007 reset_display  out  1  clears the matrix controller buffers.
REQ-008 show_display  out  1  enables the column scan.
REQ-009 desce_jogada  out  1  one-cycle pulse that shifts the lanes down.
REQ-010 prox_jogada  out  4  pattern inserted on the next desce_jogada.
REQ-011 pontos  out  6  score, saturating at 32.
REQ-012 linhas_bloqueadas  out  3  count of blocked lines.
REQ-013 fim_jogo  out  1  high while in OVER.

Function
REQ-014 The FSM SHALL have five states: IDLE, CLEAR, RUN, STEP, OVER.
REQ-015 Transitions SHALL be: IDLE->CLEAR on iniciar; CLEAR->RUN after exactly 2 cycles; RUN->STEP when tick = period-1; STEP->RUN, or STEP->OVER if updated linhas_bloqueadas = MAX_BLOQ; OVER->CLEAR on iniciar.
REQ-016 reset_display SHALL be 1 in IDLE and CLEAR, 0 otherwise; show_display SHALL be 1 in RUN, STEP and OVER.
REQ-017 desce_jogada SHALL be 1 exactly in STEP (one cycle), giving one pulse every STEP_PERIOD cycles in steady state.
REQ-018 The tick counter SHALL clear on CLEAR and STEP, and count in RUN only.
REQ-019 An 8-bit LFSR (taps 8,6,5,4; seed 8'hA5) SHALL advance every cycle; prox_jogada SHALL load lfsr[3:0] on the cycle after each STEP and on CLEAR exit, and hold otherwise.
REQ-020 An 8-entry shadow history of issued patterns SHALL shift on each STEP, mirroring the matrix lanes; the entry leaving position 7 is the due pattern.
REQ-021 captura SHALL be the OR of botoes over every RUN/STEP cycle since the last STEP; presses in the STEP cycle belong to the closing window; captura SHALL clear the cycle after STEP.
REQ-022 At STEP with a nonzero due pattern: if captura equals the pattern, pontos +1 (hold at 32); otherwise linhas_bloqueadas +1. A zero due pattern SHALL change neither count.
REQ-023 In the same STEP, pontos and linhas_bloqueadas SHALL never both change.
REQ-024 CLEAR SHALL zero pontos, linhas_bloqueadas, history, captura and tick.
REQ-025 In OVER, all counters and prox_jogada SHALL freeze; botoes SHALL be ignored.
REQ-026 iniciar SHALL be ignored in CLEAR, RUN and STEP.

Reset
REQ-027 reset_n low SHALL force, asynchronously: IDLE, LFSR=8'hA5, prox_jogada=0, pontos=0, linhas_bloqueadas=0, desce_jogada=0, show_display=0, fim_jogo=0, reset_display=1, history and captura cleared.
REQ-028 Reset asserted mid-game SHALL abort without a trailing desce_jogada pulse.

Configuration
REQ-029 Macro MATRIX_SPEEDUP_EN defined: the active period SHALL halve each time pontos crosses a multiple of 8 (floor 4 cycles); the period SHALL take effect from the next tick restart and reset to STEP_PERIOD on CLEAR.
REQ-030 MATRIX_SPEEDUP_EN undefined: the period SHALL be constant at STEP_PERIOD, with no speedup logic present.

Verification (STEP_PERIOD=4, MAX_BLOQ=2)
REQ-031 Reset, then iniciar=1 one cycle -> reset_display high 2 cycles after IDLE exit, then show_display=1; first desce_jogada 4 cycles after RUN entry, then every 4 cycles.
REQ-032 Force due pattern 4'b0101, hold botoes=4'b0101 during its window -> pontos 0->1 at that STEP, linhas_bloqueadas stays 0.
REQ-033 Due pattern 4'b0011 with botoes=4'b0001 -> linhas_bloqueadas +1; second miss -> linhas_bloqueadas=2, fim_jogo=1, desce_jogada stops.
REQ-034 In OVER, pulse iniciar -> CLEAR, pontos=0, linhas_bloqueadas=0, play resumes.
REQ-035 Drive reset_n low in the STEP cycle -> desce_jogada drops in the same cycle, all outputs take reset values.
REQ-036 With MATRIX_SPEEDUP_EN and pontos reaching 8 -> period changes from 4 to 4 (floor); with STEP_PERIOD=16 -> pulse spacing changes from 16 to 8 cycles.

Source files
------------

// File: rtl/matrix_step_scheduler.sv
// matrix_step_scheduler: game sequencer for the falling-lanes LED matrix (clear, step pulses, scoring, game over).
// Define MATRIX_SPEEDUP_EN to halve the step period each time the score crosses a multiple of 8.
module matrix_step_scheduler #(
  parameter int STEP_PERIOD = 25000000,
  parameter int MAX_BLOQ = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  output logic       reset_display,
  output logic       show_display,
  output logic       desce_jogada,
  output logic [3:0] prox_jogada,
  output logic [5:0] pontos,
  output logic [2:0] linhas_bloqueadas,
  output logic       fim_jogo
);
  localparam int TW = $clog2(STEP_PERIOD + 8);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, STEP, OVER} state_t;
  state_t state, state_nxt;
  logic clr_cnt;
  logic [TW-1:0] tick, per;
  logic [7:0] lfsr;
  logic [7:0][3:0] hist;
  logic [3:0] captura, cap_eff, due;
  logic hit, miss;
  logic [2:0] bloq_nxt;
  assign cap_eff = captura | botoes;
  assign due = hist[7];
  assign hit = state == STEP && due != 4'd0 && cap_eff == due;
  assign miss = state == STEP && due != 4'd0 && cap_eff != due;
  assign bloq_nxt = linhas_bloqueadas + {2'b0, miss};
  assign reset_display = state == IDLE || state == CLEAR;
  assign show_display = state == RUN || state == STEP || state == OVER;
  assign desce_jogada = state == STEP;
  assign fim_jogo = state == OVER;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = iniciar ? CLEAR : IDLE;
      CLEAR:   state_nxt = clr_cnt ? RUN : CLEAR;
      RUN:     state_nxt = tick == per - TW'(1) ? STEP : RUN;
      STEP:    state_nxt = bloq_nxt == 3'(MAX_BLOQ) ? OVER : RUN;
      OVER:    state_nxt = iniciar ? CLEAR : OVER;
      default: state_nxt = IDLE;
    endcase
  end
`ifdef MATRIX_SPEEDUP_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      per <= TW'(STEP_PERIOD);
    else if (state == CLEAR)
      per <= TW'(STEP_PERIOD);
    else if (hit && pontos != 6'd32 && pontos[2:0] == 3'd7)
      per <= per >= TW'(8) ? per >> 1 : TW'(4);
`else
  assign per = TW'(STEP_PERIOD);
`endif
  // The STEP cycle counts as tick 0 of the next window, so RUN resumes at 1 and pulses stay STEP_PERIOD apart.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      clr_cnt <= 1'b0;
      tick <= '0;
      lfsr <= 8'hA5;
      prox_jogada <= 4'd0;
      pontos <= 6'd0;
      linhas_bloqueadas <= 3'd0;
      hist <= '0;
      captura <= 4'd0;
    end else begin
      state <= state_nxt;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      clr_cnt <= state == CLEAR && !clr_cnt;
      if (state == CLEAR) begin
        tick <= '0;
        pontos <= 6'd0;
        linhas_bloqueadas <= 3'd0;
        hist <= '0;
        captura <= 4'd0;
        if (clr_cnt) prox_jogada <= lfsr[3:0];
      end else if (state == RUN) begin
        tick <= tick + TW'(1);
        captura <= cap_eff;
      end else if (state == STEP) begin
        tick <= TW'(1);
        captura <= 4'd0;
        hist <= {hist[6:0], prox_jogada};
        prox_jogada <= lfsr[3:0];
        pontos <= pontos + {5'b0, hit && pontos != 6'd32};
        linhas_bloqueadas <= bloq_nxt;
      end
    end
endmodule
